// File: rtl/jtcop_obj_dma_if.sv
// Bus between the object DMA writer and the CPU object RAM / bus arbiter.
// The DMA side is the master: it requests the bus and issues RAM reads.
interface jtcop_obj_dma_if #(
  parameter int AW = 10
);
  logic          bus_req;
  logic          bus_ack;
  logic          ram_cs;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_dout;

  modport master (
    output bus_req,
    output ram_cs,
    output ram_addr,
    input  bus_ack,
    input  ram_dout
  );

  modport slave (
    input  bus_req,
    input  ram_cs,
    input  ram_addr,
    output bus_ack,
    output ram_dout
  );
endinterface

// File: rtl/jtcop_obj_dma.sv
// Object table writer: copies object RAM into the back bank of a double-buffered
// table on a DMA trigger and swaps banks during vertical blank.
module jtcop_obj_dma #(
  parameter int RAM_LAT = 1,
  parameter int AW      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_lvbl,
  input  logic                  i_dma_trig,
  jtcop_obj_dma_if.master       bus,
  input  logic [AW-1:0]         i_tbl_addr,
  output logic [15:0]           o_tbl_dout,
  output logic                  o_busy,
  output logic                  o_bank
);

  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VB,
    REQ,
    COPY,
    SWAP
  } state_t;

  state_t               r_state;
  logic                 r_pending;
  logic                 r_lvblD;
  logic                 r_busReq;
  logic                 r_ramCs;
  logic [AW-1:0]        r_ramAddr;
  logic                 r_allIssued;
  logic                 r_bank;
  logic [RAM_LAT-1:0]   r_dlValid;
  logic [AW-1:0]        r_dlAddr [RAM_LAT];
  logic [15:0]          r_table [2**(AW+1)];
  logic [15:0]          r_tblDout;

  logic                 w_vbFall;
  logic                 w_issueDone;
  logic                 w_lastWrite;
  logic                 w_swapNow;
  logic                 w_frontBank;
  logic [AW-1:0]        w_nextAddr;

  // While ram_cs is low, ram_addr already holds the next unissued address
  assign w_vbFall    = r_lvblD & ~i_lvbl;
  assign w_nextAddr  = r_ramCs ? r_ramAddr + 1'b1 : r_ramAddr;
  assign w_issueDone = r_allIssued | (r_ramCs & (r_ramAddr == LAST));
  assign w_lastWrite = r_dlValid[RAM_LAT-1] & (r_dlAddr[RAM_LAT-1] == LAST);
  assign w_swapNow   = (r_state == SWAP) & ~i_lvbl;
  assign w_frontBank = r_bank ^ w_swapNow;

  assign bus.bus_req  = r_busReq;
  assign bus.ram_cs   = r_ramCs;
  assign bus.ram_addr = r_ramAddr;
  assign o_busy       = r_pending | (r_state != IDLE);
  assign o_bank       = r_bank;
  assign o_tbl_dout   = r_tblDout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_lvblD     <= 1'b0;
      r_busReq    <= 1'b0;
      r_ramCs     <= 1'b0;
      r_ramAddr   <= '0;
      r_allIssued <= 1'b0;
      r_bank      <= 1'b0;
    end else begin
      r_lvblD <= i_lvbl;
      // A trigger landing on the cycle pending is consumed merges into that copy
      if (r_state == WAIT_VB && w_vbFall) begin
        r_pending <= 1'b0;
      end else if (i_dma_trig) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_pending) r_state <= WAIT_VB;
        end
        WAIT_VB: begin
          if (w_vbFall) begin
            r_state     <= REQ;
            r_busReq    <= 1'b1;
            r_ramAddr   <= '0;
            r_allIssued <= 1'b0;
          end
        end
        REQ: begin
          if (bus.bus_ack) r_state <= COPY;
        end
        COPY: begin
          r_allIssued <= w_issueDone;
          r_ramAddr   <= w_nextAddr;
          r_ramCs     <= bus.bus_ack & ~w_issueDone;
          if (w_lastWrite) begin
            r_busReq <= 1'b0;
            r_ramCs  <= 1'b0;
            r_state  <= SWAP;
          end
        end
        SWAP: begin
          if (!i_lvbl) begin
            r_bank  <= ~r_bank;
            r_state <= r_pending ? WAIT_VB : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Address/valid delay line aligning each issued address with its returning data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dlValid <= '0;
      for (int i = 0; i < RAM_LAT; i++) r_dlAddr[i] <= '0;
    end else begin
      r_dlValid[0] <= r_ramCs;
      r_dlAddr[0]  <= r_ramAddr;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_dlValid[i] <= r_dlValid[i-1];
        r_dlAddr[i]  <= r_dlAddr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_dlValid[RAM_LAT-1]) r_table[{~r_bank, r_dlAddr[RAM_LAT-1]}] <= bus.ram_dout;
  end

  // The read follows the bank that will be front after this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tblDout <= '0;
    else     r_tblDout <= r_table[{w_frontBank, i_tbl_addr}];
  end

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Scoreboard bench for jtcop_obj_dma: RAM model with RAM_LAT=3, arbiter model,
// copy-address monitor and a front-bank reference model checked through tbl_addr reads.
module tb_jtcop_obj_dma;
  localparam int RAM_LAT = 3;
  localparam int AW      = 10;
  localparam int N       = 2**AW;
  localparam int TMO     = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          lvbl;
  logic          trig;
  logic          ackBlock;
  logic [AW-1:0] tblAddr;
  logic [15:0]   tblDout;
  logic          busy;
  logic          bank;

  logic [15:0]   ramMem [N];
  logic [15:0]   frontModel [N];
  logic [15:0]   pipe [RAM_LAT];
  logic [15:0]   expQ [$];

  int checks = 0;
  int errors = 0;
  int expAddr = 0;
  int csCount = 0;

  jtcop_obj_dma_if #(.AW(AW)) busIf ();

  assign busIf.bus_ack  = busIf.bus_req & ~ackBlock;
  assign busIf.ram_dout = pipe[RAM_LAT-1];

  jtcop_obj_dma #(.RAM_LAT(RAM_LAT), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_lvbl     (lvbl),
    .i_dma_trig (trig),
    .bus        (busIf),
    .i_tbl_addr (tblAddr),
    .o_tbl_dout (tblDout),
    .o_busy     (busy),
    .o_bank     (bank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= ramMem[busIf.ram_addr];
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every issued read must follow the address sequence of the current copy
  always @(negedge clk) begin
    if (busIf.ram_cs === 1'b1) begin
      checkOutput("addrSeq", 32'(busIf.ram_addr), 32'(expAddr));
      expAddr = expAddr + 1;
      csCount = csCount + 1;
    end
  end

  task automatic applyStimulus(input int addr);
    tblAddr = addr[AW-1:0];
    expQ.push_back(frontModel[addr]);
  endtask

  task automatic readBlock(input int start, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(start + i);
      @(negedge clk);
      checkOutput(tag, 32'(tblDout), 32'(expQ.pop_front()));
    end
  endtask

  task automatic pulseTrig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic waitAddr(input int a, input string tag);
    int n = 0;
    while (!(busIf.ram_cs === 1'b1 && busIf.ram_addr == a[AW-1:0]) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(n < TMO), 32'd1);
  endtask

  // kind 0: wait for busy low, kind 1: wait for bus_req low
  task automatic waitLow(input int kind, input string tag);
    int n = 0;
    while (((kind == 0) ? busy : busIf.bus_req) !== 1'b0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(n < TMO), 32'd1);
  endtask

  task automatic startCopy();
    expAddr = 0;
    csCount = 0;
    lvbl = 1'b1;
    repeat (3) @(negedge clk);
    pulseTrig();
    repeat (2) @(negedge clk);
    lvbl = 1'b0;
  endtask

  task automatic latchFront();
    for (int i = 0; i < N; i++) frontModel[i] = ramMem[i];
  endtask

  initial begin
    rst = 1'b1;
    lvbl = 1'b1;
    trig = 1'b0;
    ackBlock = 1'b0;
    tblAddr = '0;
    for (int i = 0; i < N; i++) begin
      ramMem[i] = 16'(i) ^ 16'hA5A5;
      frontModel[i] = '0;
    end
    for (int i = 0; i < RAM_LAT; i++) pipe[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusReq", 32'(busIf.bus_req), 32'd0);
    checkOutput("rstRamCs", 32'(busIf.ram_cs), 32'd0);
    checkOutput("rstRamAddr", 32'(busIf.ram_addr), 32'd0);
    checkOutput("rstTblDout", 32'(tblDout), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstBank", 32'(bank), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Trigger during active display: no bus request until vblank starts
    pulseTrig();
    repeat (20) @(negedge clk);
    checkOutput("noReqInDisplay", 32'(busIf.bus_req), 32'd0);
    checkOutput("busyWaitVb", 32'(busy), 32'd1);
    lvbl = 1'b0;
    waitLow(0, "t1Done");
    checkOutput("t1Bank", 32'(bank), 32'd1);
    checkOutput("t1CsCount", 32'(csCount), 32'(N));
    latchFront();
    readBlock(30, 16, "t1Read");

    // Reset in the middle of a copy
    startCopy();
    waitAddr(512, "t2Reach512");
    rst = 1'b1;
    #1;
    checkOutput("midRstBusReq", 32'(busIf.bus_req), 32'd0);
    checkOutput("midRstRamCs", 32'(busIf.ram_cs), 32'd0);
    checkOutput("midRstBank", 32'(bank), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Second trigger during copy: two copies, two swaps
    for (int i = 0; i < N; i++) ramMem[i] = 16'(i * 7 + 16'h1357);
    startCopy();
    waitAddr(100, "t3Reach100");
    pulseTrig();
    waitLow(1, "t3ReqLow");
    repeat (2) @(negedge clk);
    checkOutput("t3Bank1", 32'(bank), 32'd1);
    checkOutput("t3BusyPending", 32'(busy), 32'd1);
    checkOutput("t3CsCount1", 32'(csCount), 32'(N));
    latchFront();
    readBlock(96, 8, "t3ReadC");
    for (int i = 0; i < N; i++) ramMem[i] = ~16'(i) ^ 16'h0F0F;
    expAddr = 0;
    csCount = 0;
    lvbl = 1'b1;
    repeat (3) @(negedge clk);
    lvbl = 1'b0;
    waitLow(0, "t3Done");
    checkOutput("t3Bank0", 32'(bank), 32'd0);
    checkOutput("t3CsCount2", 32'(csCount), 32'(N));
    latchFront();
    readBlock(1016, 8, "t3ReadD");

    // Bus pause at word 300, display resumes mid-copy, swap deferred to next vblank
    for (int i = 0; i < N; i++) ramMem[i] = (16'(i) << 6) ^ 16'(i) ^ 16'h3C3C;
    startCopy();
    waitAddr(299, "t4Reach299");
    ackBlock = 1'b1;
    @(negedge clk);
    lvbl = 1'b1;
    repeat (49) @(negedge clk);
    checkOutput("pauseRamCs", 32'(busIf.ram_cs), 32'd0);
    checkOutput("pauseRamAddr", 32'(busIf.ram_addr), 32'd300);
    checkOutput("pauseBusReq", 32'(busIf.bus_req), 32'd1);
    checkOutput("pauseCsCount", 32'(csCount), 32'd300);
    ackBlock = 1'b0;
    waitLow(1, "t4ReqLow");
    repeat (3) @(negedge clk);
    checkOutput("deferBank", 32'(bank), 32'd0);
    checkOutput("deferBusy", 32'(busy), 32'd1);
    checkOutput("t4CsCount", 32'(csCount), 32'(N));
    readBlock(295, 10, "oldFront");
    lvbl = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("swapBank", 32'(bank), 32'd1);
    checkOutput("swapBusy", 32'(busy), 32'd0);
    latchFront();
    readBlock(0, N, "fullTable");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
